// File: rtl/instr_mem_loader.sv
// Boot-time instruction loader: packs a little-endian byte stream into 32-bit words and
// writes them to instruction memory, keeping the core in reset (busy) for the whole session.
module instr_mem_loader #(
    parameter int unsigned MEM_WORDS = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  num_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {StIdle, StCollect, StWrite, StFinish} state_e;

    state_e      state_q, state_d;
    logic [5:0]  num_q, num_d;
    logic [5:0]  word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] asm_q, asm_d;
    logic        error_q, error_d;
    logic        start_ok;
    logic        last_word;

    assign start_ok = (num_words != 6'd0) && (32'(num_words) <= MEM_WORDS);
    // Second term bounds the write address even if the latched count were ever corrupted.
    assign last_word = (word_idx_q == num_q - 6'd1) || (32'(word_idx_q) >= MEM_WORDS - 1);

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        error_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (start_ok) begin
                        num_d      = num_words;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        asm_d      = '0;
                        state_d    = StCollect;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            StCollect: begin
                if (byte_valid) begin
                    asm_d[8*byte_idx_q +: 8] = byte_data;
                    byte_idx_d               = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                word_idx_d = word_idx_q + 6'd1;
                byte_idx_d = '0;
                asm_d      = '0;
                state_d    = last_word ? StFinish : StCollect;
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            num_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            error_q    <= error_d;
        end
    end

    // All outputs decode from reset-cleared registers, so they drop as soon as rst_n falls.
    assign byte_ready  = (state_q == StCollect);
    assign mem_wr_en   = (state_q == StWrite);
    assign mem_wr_addr = mem_wr_en ? {24'd0, word_idx_q, 2'b00} : 32'd0;
    assign mem_wr_data = mem_wr_en ? asm_q : 32'd0;
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StFinish);
    assign error       = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a session vector table plus hand-written sequences
// for write latency, mid-session reset and a start held high during a session.
module tb_instr_mem_loader;

    localparam int unsigned MEM_WORDS = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  num_words = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    instr_mem_loader #(
        .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    int done_cnt = 0;
    int err_cnt = 0;
    int busy_cnt = 0;
    int bad_out_cnt = 0;

    // Passive monitor; tests compare deltas of these counters.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wr_en) begin
                wr_addr_log.push_back(mem_wr_addr);
                wr_data_log.push_back(mem_wr_data);
                if (mem_wr_addr > (MEM_WORDS - 1) * 4 || mem_wr_addr[1:0] != 2'b00) bad_out_cnt++;
            end else if (mem_wr_addr != 32'd0 || mem_wr_data != 32'd0) begin
                bad_out_cnt++;
            end
            if (done) done_cnt++;
            if (error) err_cnt++;
            if (busy) busy_cnt++;
        end
    end

    typedef struct packed {
        logic [5:0]  nw;
        logic [3:0]  nbytes;
        logic [63:0] bytes;
        logic [3:0]  max_gap;
        logic [1:0]  exp_writes;
        logic [63:0] exp_addr;
        logic [63:0] exp_data;
        logic [1:0]  exp_err;
        logic [1:0]  exp_done;
    } vec_t;

    localparam int NV = 4;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got = 1'b0;
        byte_valid = 1'b0;
        repeat (gap) begin
            byte_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk);
                #1;
                got = 1'b1;
            end
        end
        byte_valid = 1'b0;
        if (!got) check("byte accept timeout", 32'(byte_ready), 32'd1);
    endtask

    task automatic do_start(input logic [5:0] n);
        start     = 1'b1;
        num_words = n;
        @(posedge clk);
        #1;
        start     = 1'b0;
        num_words = 6'($urandom);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int t = 0; t < 300 && !idle; t++) begin
            @(negedge clk);
            idle = !busy;
        end
        if (!idle) check("idle timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int base_wr, base_done, base_err, base_busy;

        vecs[0] = '{nw: 6'd1, nbytes: 4'd4, bytes: 64'h0000_0000_0000_0013, max_gap: 4'd0,
                    exp_writes: 2'd1, exp_addr: 64'h0, exp_data: 64'h0000_0000_0000_0013,
                    exp_err: 2'd0, exp_done: 2'd1};
        vecs[1] = '{nw: 6'd2, nbytes: 4'd8, bytes: 64'h0010_0293_00B5_05B3, max_gap: 4'd3,
                    exp_writes: 2'd2, exp_addr: 64'h0000_0004_0000_0000,
                    exp_data: 64'h0010_0293_00B5_05B3, exp_err: 2'd0, exp_done: 2'd1};
        vecs[2] = '{nw: 6'd0, nbytes: 4'd0, bytes: 64'h0, max_gap: 4'd0,
                    exp_writes: 2'd0, exp_addr: 64'h0, exp_data: 64'h0,
                    exp_err: 2'd1, exp_done: 2'd0};
        vecs[3] = '{nw: 6'd34, nbytes: 4'd0, bytes: 64'h0, max_gap: 4'd0,
                    exp_writes: 2'd0, exp_addr: 64'h0, exp_data: 64'h0,
                    exp_err: 2'd1, exp_done: 2'd0};

        // Reset held with random inputs: every output must stay 0.
        for (int i = 0; i < 8; i++) begin
            start      = 1'($urandom);
            num_words  = 6'($urandom);
            byte_valid = 1'($urandom);
            byte_data  = 8'($urandom);
            @(negedge clk);
            check($sformatf("reset ctl %0d", i),
                  32'({byte_ready, mem_wr_en, busy, done, error}), 32'd0);
            check($sformatf("reset addr %0d", i), mem_wr_addr, 32'd0);
            check($sformatf("reset data %0d", i), mem_wr_data, 32'd0);
        end
        start = 1'b0;
        byte_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after reset", 32'({byte_ready, mem_wr_en, busy, done, error}), 32'd0);

        // Table-driven sessions.
        for (int i = 0; i < NV; i++) begin
            base_wr   = wr_addr_log.size();
            base_done = done_cnt;
            base_err  = err_cnt;
            base_busy = busy_cnt;
            @(posedge clk);
            #1;
            do_start(vecs[i].nw);
            for (int b = 0; b < int'(vecs[i].nbytes); b++) begin
                send_byte(vecs[i].bytes[8*b +: 8], int'($urandom_range(int'(vecs[i].max_gap), 0)));
            end
            wait_idle();
            repeat (3) @(negedge clk);
            check($sformatf("v%0d writes", i), wr_addr_log.size() - base_wr,
                  32'(vecs[i].exp_writes));
            for (int k = 0; k < int'(vecs[i].exp_writes); k++) begin
                check($sformatf("v%0d addr%0d", i, k),
                      (base_wr + k < wr_addr_log.size()) ? wr_addr_log[base_wr + k] : 32'hxxxx_xxxx,
                      vecs[i].exp_addr[32*k +: 32]);
                check($sformatf("v%0d data%0d", i, k),
                      (base_wr + k < wr_data_log.size()) ? wr_data_log[base_wr + k] : 32'hxxxx_xxxx,
                      vecs[i].exp_data[32*k +: 32]);
            end
            check($sformatf("v%0d errors", i), err_cnt - base_err, 32'(vecs[i].exp_err));
            check($sformatf("v%0d dones", i), done_cnt - base_done, 32'(vecs[i].exp_done));
            check($sformatf("v%0d busy seen", i), 32'(busy_cnt != base_busy),
                  32'(vecs[i].exp_writes != 2'd0));
        end

        // Exact cycle timing of a one-word session.
        base_wr = wr_addr_log.size();
        do_start(6'd1);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        byte_valid = 1'b1;
        byte_data  = 8'h00;
        @(negedge clk);
        check("t1 ready on byte4", 32'(byte_ready), 32'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        @(negedge clk);
        check("t1 wr_en after byte4", 32'(mem_wr_en), 32'd1);
        check("t1 addr", mem_wr_addr, 32'h0);
        check("t1 data", mem_wr_data, 32'h0000_0013);
        @(negedge clk);
        check("t1 done cycle", 32'({mem_wr_en, done, busy}), 32'b011);
        @(negedge clk);
        check("t1 back to idle", 32'({mem_wr_en, done, busy}), 32'b000);
        check("t1 single write", wr_addr_log.size() - base_wr, 32'd1);

        // Reset mid-session, then a fresh session must start at address 0.
        base_wr   = wr_addr_log.size();
        base_done = done_cnt;
        do_start(6'd3);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 1);
        send_byte(8'h66, 0);
        rst_n = 1'b0;
        #1;
        check("async reset outputs", 32'({byte_ready, mem_wr_en, busy, done, error}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_start(6'd1);
        send_byte(8'h6F, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_idle();
        repeat (2) @(negedge clk);
        check("rst writes", wr_addr_log.size() - base_wr, 32'd2);
        if (wr_addr_log.size() - base_wr >= 2) begin
            check("rst addr0", wr_addr_log[base_wr], 32'h0);
            check("rst data0", wr_data_log[base_wr], 32'h4433_2211);
            check("rst addr1", wr_addr_log[base_wr + 1], 32'h0);
            check("rst data1", wr_data_log[base_wr + 1], 32'h0000_006F);
        end
        check("rst dones", done_cnt - base_done, 32'd1);

        // start held high (with an out-of-range count) during a two-word session.
        base_wr   = wr_addr_log.size();
        base_done = done_cnt;
        base_err  = err_cnt;
        start     = 1'b1;
        num_words = 6'd2;
        @(posedge clk);
        #1;
        num_words = 6'd5;
        for (int b = 1; b <= 8; b++) send_byte(8'(b), b % 2);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("hold writes", wr_addr_log.size() - base_wr, 32'd2);
        if (wr_addr_log.size() - base_wr >= 2) begin
            check("hold addr1", wr_addr_log[base_wr + 1], 32'h4);
            check("hold data0", wr_data_log[base_wr], 32'h0403_0201);
            check("hold data1", wr_data_log[base_wr + 1], 32'h0807_0605);
        end
        check("hold dones", done_cnt - base_done, 32'd1);
        check("hold errors", err_cnt - base_err, 32'd0);

        check("idle outputs zero / addr bounds", bad_out_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 33: instruction memory depth in 32-bit words.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: request a load session; sampled only in IDLE.
REQ-005 SHALL have port num_words, input, 6: word count of the session, sampled with start.
REQ-006 SHALL have port byte_valid, input, 1: byte_data holds a valid byte.
REQ-007 SHALL have port byte_data, input, 8: incoming program byte.
REQ-008 SHALL have port byte_ready, output, 1: loader accepts a byte this cycle.
REQ-009 SHALL have port mem_wr_en, output, 1: write strobe to instruction memory.
REQ-010 SHALL have port mem_wr_addr, output, 32: byte address of the write, always word-aligned (bits [1:0] = 0).
REQ-011 SHALL have port mem_wr_data, output, 32: assembled instruction word.
REQ-012 SHALL have port busy, output, 1: session in progress; the core is held in reset while it is high.
REQ-013 SHALL have port done, output, 1: one-cycle pulse at session end.
REQ-014 SHALL have port error, output, 1: one-cycle pulse when a start request is rejected.

Function
REQ-015 SHALL implement the FSM states IDLE, COLLECT, WRITE and FINISH.
REQ-016 In IDLE with start=1 and 1 <= num_words <= MEM_WORDS, SHALL latch num_words, clear the word index and the byte index, and go to COLLECT.
REQ-017 In IDLE with start=1 and num_words = 0 or num_words > MEM_WORDS, SHALL pulse error for one cycle, perform no write, and stay in IDLE.
REQ-018 SHALL ignore start in every state other than IDLE.
REQ-019 SHALL drive byte_ready=1 only in COLLECT.
REQ-020 SHALL accept a byte only in a cycle where byte_valid and byte_ready are both 1; a low byte_valid stalls the loader indefinitely with no timeout.
REQ-021 SHALL assemble bytes little-endian: the first accepted byte goes to [7:0], then [15:8], [23:16], [31:24].
REQ-022 SHALL move from COLLECT to WRITE in the cycle the 4th byte is accepted.
REQ-023 SHALL, in WRITE, assert mem_wr_en for exactly one cycle, with mem_wr_data = the assembled word and mem_wr_addr = word_index*4.
REQ-024 SHALL assert mem_wr_en in the cycle after the 4th byte is accepted (latency 1).
REQ-025 SHALL, after WRITE, increment the word index and clear the byte index.
REQ-026 After WRITE, SHALL go to FINISH if the word just written was word num_words-1; otherwise SHALL go back to COLLECT.
REQ-027 SHALL, in FINISH, pulse done for one cycle and then return to IDLE.
REQ-028 SHALL hold mem_wr_en=0 in every state except WRITE.
REQ-029 SHALL drive mem_wr_addr and mem_wr_data to 0 whenever mem_wr_en=0.
REQ-030 SHALL drive busy=1 in COLLECT, WRITE and FINISH, and busy=0 in IDLE.
REQ-031 SHALL ignore byte_valid outside COLLECT; those bytes are neither consumed nor buffered.
REQ-032 SHALL never write past address (MEM_WORDS-1)*4.
REQ-033 SHALL make the word index wide enough that it does not wrap for MEM_WORDS up to 63.

Reset
REQ-034 While rst_n=0, SHALL force the state to IDLE and force byte_ready, mem_wr_en, mem_wr_addr, mem_wr_data, busy, done and error all to 0, immediately and without waiting for clk.
REQ-035 A reset in the middle of a session SHALL discard any partially assembled word without writing it.
REQ-036 After reset is released, the next session SHALL start at address 0.
REQ-037 SHALL clear all internal counters and the assembly register on reset.

Verification
REQ-038 Bench SHALL cover: rst_n low with random inputs -> all outputs 0, state IDLE, no mem_wr_en.
REQ-039 Bench SHALL cover: num_words=1, then bytes 13,00,00,00 back-to-back -> one write, addr 0x0, data 0x00000013, in the cycle after byte 4; done pulses the next cycle; busy falls with the return to IDLE.
REQ-040 Bench SHALL cover: num_words=2, bytes B3,05,B5,00,93,02,10,00 with random gaps in byte_valid -> writes (0x0, 0x00B505B3) and (0x4, 0x00100293); exactly 2 mem_wr_en pulses.
REQ-041 Bench SHALL cover: start with num_words=0, then with num_words=34 -> one error pulse each, busy stays 0, no writes.
REQ-042 Bench SHALL cover: num_words=3, rst_n pulsed low after 6 bytes -> only the write to 0x0 occurs; after reset, num_words=1 with bytes 6F,00,00,00 -> write at 0x0, data 0x0000006F.
REQ-043 Bench SHALL cover: start=1 with num_words=5 held continuously during a 2-word session -> no restart and no error; exactly 2 writes and 1 done pulse.
